// File: rtl/fp_round_unit.sv
// rtl/fp_round_unit.sv - two-stage IEEE-754 single-precision rounding stage with valid/ready handshake
// Optional accrued-flags register: define FP_ROUND_ACCRUED_FLAGS_EN.
module fp_round_unit #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clk_en_i,
    input  logic [EXP_W+MANT_W:0]     to_round_i,
    input  logic [2:0]                grs_i,
    input  logic [2:0]                round_mode_i,
    input  logic [2:0]                frm_i,
    input  logic                      overflow_i,
    input  logic                      underflow_i,
    input  logic                      invalid_op_i,
    input  logic                      zero_divide_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [EXP_W+MANT_W:0]     result_o,
    output logic [4:0]                fflags_o,
    output logic                      valid_o,
`ifdef FP_ROUND_ACCRUED_FLAGS_EN
    input  logic                      fflags_clr_i,
    output logic [4:0]                fflags_acc_o,
`endif
    input  logic                      ready_i
);
    localparam int W = 1 + EXP_W + MANT_W;

    localparam logic [W-2:0] MAG_INF  = {{EXP_W{1'b1}}, {MANT_W{1'b0}}};
    localparam logic [W-2:0] MAG_MAX  = {{(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
    localparam logic [W-1:0] QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Pipeline registers
    logic             s1_valid;
    logic             s1_sign;
    logic [W-2:0]     s1_mag;
    logic             s1_inc;
    logic             s1_nx;
    logic [2:0]       s1_rm;
    logic             s1_ovf_in;
    logic             s1_uf_in;
    logic             s1_byp;
    logic [W-1:0]     s1_byp_result;
    logic [4:0]       s1_byp_flags;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv  = ~valid_o | ready_i;
    assign s1_adv  = ~s1_valid | s2_adv;
    assign ready_o = s1_adv;

    // Stage-1 decode
    logic [2:0]        rm_eff;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              g_bit, r_bit, s_bit, x_bit, l_bit;
    logic              reserved_rm;
    logic              is_nan, is_inf, is_zero;
    logic              inc;
    logic              byp;
    logic [W-1:0]      byp_result;
    logic [4:0]        byp_flags;

    assign rm_eff  = (round_mode_i == 3'b111) ? frm_i : round_mode_i;
    assign in_sign = to_round_i[W-1];
    assign in_exp  = to_round_i[W-2:MANT_W];
    assign in_mant = to_round_i[MANT_W-1:0];
    assign g_bit   = grs_i[2];
    assign r_bit   = grs_i[1];
    assign s_bit   = grs_i[0];
    assign x_bit   = |grs_i;
    assign l_bit   = in_mant[0];

    // A dynamic frm of 101..111 is just as illegal as a static reserved rm.
    assign reserved_rm = (rm_eff > RM_RMM);
    assign is_nan      = (&in_exp) & (|in_mant);
    assign is_inf      = (&in_exp) & ~(|in_mant);
    assign is_zero     = ~(|in_exp) & ~(|in_mant) & ~x_bit;

    always_comb begin
        inc = 1'b0;
        case (rm_eff)
            RM_RNE:  inc = g_bit & (l_bit | r_bit | s_bit);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = in_sign & x_bit;
            RM_RUP:  inc = ~in_sign & x_bit;
            RM_RMM:  inc = g_bit;
            default: inc = 1'b0;
        endcase
    end

    always_comb begin
        byp        = 1'b1;
        byp_result = to_round_i;
        byp_flags  = 5'b00000;
        if (invalid_op_i | reserved_rm | is_nan) begin
            byp_result = QNAN;
            byp_flags  = {invalid_op_i | reserved_rm, 4'b0000};
        end else if (zero_divide_i) begin
            byp_flags  = 5'b01000;
        end else if (is_inf | is_zero) begin
            byp_flags  = 5'b00000;
        end else begin
            byp        = 1'b0;
        end
    end

    // Stage-2 rounding: a mantissa carry ripples into the exponent field.
    logic [W-2:0] sum;
    logic         ovf;
    logic [W-2:0] ovf_mag;
    logic [W-1:0] next_result;
    logic [4:0]   next_flags;

    assign sum = s1_mag + {{(W-2){1'b0}}, s1_inc};
    assign ovf = (&sum[W-2:MANT_W]) | s1_ovf_in;

    always_comb begin
        ovf_mag = MAG_INF;
        case (s1_rm)
            RM_RTZ:  ovf_mag = MAG_MAX;
            RM_RDN:  ovf_mag = s1_sign ? MAG_INF : MAG_MAX;
            RM_RUP:  ovf_mag = s1_sign ? MAG_MAX : MAG_INF;
            default: ovf_mag = MAG_INF;
        endcase
    end

    always_comb begin
        next_result = {s1_sign, sum};
        next_flags  = {3'b000, s1_uf_in & s1_nx, s1_nx};
        if (s1_byp) begin
            next_result = s1_byp_result;
            next_flags  = s1_byp_flags;
        end else if (ovf) begin
            next_result = {s1_sign, ovf_mag};
            next_flags  = 5'b00101;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_mag        <= '0;
            s1_inc        <= 1'b0;
            s1_nx         <= 1'b0;
            s1_rm         <= 3'b000;
            s1_ovf_in     <= 1'b0;
            s1_uf_in      <= 1'b0;
            s1_byp        <= 1'b0;
            s1_byp_result <= '0;
            s1_byp_flags  <= 5'b00000;
            valid_o       <= 1'b0;
            result_o      <= '0;
            fflags_o      <= 5'b00000;
        end else if (clk_en_i) begin
            if (s1_adv) begin
                s1_valid <= valid_i;
                if (valid_i) begin
                    s1_sign       <= in_sign;
                    s1_mag        <= to_round_i[W-2:0];
                    s1_inc        <= inc;
                    s1_nx         <= x_bit;
                    s1_rm         <= rm_eff;
                    s1_ovf_in     <= overflow_i;
                    s1_uf_in      <= underflow_i;
                    s1_byp        <= byp;
                    s1_byp_result <= byp_result;
                    s1_byp_flags  <= byp_flags;
                end
            end
            if (s2_adv) begin
                valid_o <= s1_valid;
                if (s1_valid) begin
                    result_o <= next_result;
                    fflags_o <= next_flags;
                end
            end
        end
    end

`ifdef FP_ROUND_ACCRUED_FLAGS_EN
    // A handshake in the same cycle as a clear wins, so its flags are never dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fflags_acc_o <= 5'b00000;
        end else if (clk_en_i) begin
            if (valid_o & ready_i) begin
                fflags_acc_o <= fflags_acc_o | fflags_o;
            end else if (fflags_clr_i) begin
                fflags_acc_o <= 5'b00000;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_round_unit.sv
// tb/tb_fp_round_unit.sv - self-checking bench for fp_round_unit
module tb_fp_round_unit;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        clk_en_i = 1'b1;
    logic [31:0] to_round_i = '0;
    logic [2:0]  grs_i = '0;
    logic [2:0]  round_mode_i = '0;
    logic [2:0]  frm_i = '0;
    logic        overflow_i = 1'b0;
    logic        underflow_i = 1'b0;
    logic        invalid_op_i = 1'b0;
    logic        zero_divide_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
`ifdef FP_ROUND_ACCRUED_FLAGS_EN
    logic        fflags_clr_i = 1'b0;
    logic [4:0]  fflags_acc_o;
`endif

    fp_round_unit #(.EXP_W(8), .MANT_W(23)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .clk_en_i      (clk_en_i),
        .to_round_i    (to_round_i),
        .grs_i         (grs_i),
        .round_mode_i  (round_mode_i),
        .frm_i         (frm_i),
        .overflow_i    (overflow_i),
        .underflow_i   (underflow_i),
        .invalid_op_i  (invalid_op_i),
        .zero_divide_i (zero_divide_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .result_o      (result_o),
        .fflags_o      (fflags_o),
        .valid_o       (valid_o),
`ifdef FP_ROUND_ACCRUED_FLAGS_EN
        .fflags_clr_i  (fflags_clr_i),
        .fflags_acc_o  (fflags_acc_o),
`endif
        .ready_i       (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic [2:0]  frm;
        logic        ovf;
        logic        uf;
        logic        inv;
        logic        dz;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        int          id;
    } exp_t;

    vec_t vecs[20];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int in_accepts = 0;
    int out_count = 0;

    function automatic vec_t mk(logic [31:0] a, logic [2:0] grs, logic [2:0] rm, logic [2:0] frm,
                                logic ovf, logic uf, logic inv, logic dz,
                                logic [31:0] res, logic [4:0] fl);
        vec_t v;
        v.a = a; v.grs = grs; v.rm = rm; v.frm = frm;
        v.ovf = ovf; v.uf = uf; v.inv = inv; v.dz = dz;
        v.res = res; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v, input int id);
        exp_t e;
        int   n;
        to_round_i    = v.a;
        grs_i         = v.grs;
        round_mode_i  = v.rm;
        frm_i         = v.frm;
        overflow_i    = v.ovf;
        underflow_i   = v.uf;
        invalid_op_i  = v.inv;
        zero_divide_i = v.dz;
        valid_i       = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ready_o && n < 200);
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout id=%0d actual=ready_low expected=accept", id);
        end else begin
            e.res = v.res;
            e.fl  = v.fl;
            e.id  = id;
            sb.push_back(e);
            in_accepts++;
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
        end
        @(posedge clk_i);
        #1;
    endtask

    // Output monitor: the handshake seen at a negedge completes at the next posedge.
    always @(negedge clk_i) begin
        if (rst_n_i && clk_en_i && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h expected=none", result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("result_%0d", e.id), result_o, e.res);
                chk($sformatf("fflags_%0d", e.id), {27'd0, fflags_o}, {27'd0, e.fl});
                out_count++;
            end
        end
    end

    initial begin
        int acc0;
        int out0;
        int n;
        //            a             grs     rm      frm     ovf   uf    inv   dz    res           fl
        vecs[0]  = mk(32'h3F800001, 3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F800002, 5'b00001);
        vecs[1]  = mk(32'h3F800000, 3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 5'b00001);
        vecs[2]  = mk(32'h3FFFFFFF, 3'b110, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'b00001);
        vecs[3]  = mk(32'h3FFFFFFF, 3'b110, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3FFFFFFF, 5'b00001);
        vecs[4]  = mk(32'h7F7FFFFF, 3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 5'b00101);
        vecs[5]  = mk(32'h7F7FFFFF, 3'b100, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 5'b00101);
        vecs[6]  = mk(32'hFF7FFFFF, 3'b100, 3'b011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFF7FFFFF, 5'b00101);
        vecs[7]  = mk(32'h3F800000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7FC00000, 5'b10000);
        vecs[8]  = mk(32'hFF800000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFF800000, 5'b01000);
        vecs[9]  = mk(32'h3F800000, 3'b000, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FC00000, 5'b10000);
        vecs[10] = mk(32'h3F800000, 3'b001, 3'b111, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F800001, 5'b00001);
        vecs[11] = mk(32'h7F800001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FC00000, 5'b00000);
        vecs[12] = mk(32'h7F800000, 3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 5'b00000);
        vecs[13] = mk(32'h80000000, 3'b000, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 5'b00000);
        vecs[14] = mk(32'h00000001, 3'b100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000002, 5'b00011);
        vecs[15] = mk(32'h3F800000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7F800000, 5'b00101);
        vecs[16] = mk(32'hBF800000, 3'b001, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hBF800001, 5'b00001);
        vecs[17] = mk(32'h3F800000, 3'b100, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F800001, 5'b00001);
        vecs[18] = mk(32'h007FFFFF, 3'b100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00800000, 5'b00011);
        vecs[19] = mk(32'hFF7FFFFF, 3'b100, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF800000, 5'b00101);

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_valid_o", {31'd0, valid_o}, 32'd0);
        chk("reset_result_o", result_o, 32'd0);
        chk("reset_fflags_o", {27'd0, fflags_o}, 32'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Streaming table with downstream always ready.
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) send(vecs[i], i);
        wait_drain();

        // Backpressure: two accepts fill the pipe, then ready_o must drop.
        ready_i = 1'b0;
        acc0 = in_accepts;
        out0 = out_count;
        fork
            begin
                for (int k = 0; k < 4; k++) send(vecs[k], 100 + k);
            end
        join_none
        repeat (4) @(negedge clk_i);
        chk("bp_accepts", in_accepts - acc0, 32'd2);
        chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
        chk("bp_valid_held", {31'd0, valid_o}, 32'd1);
        chk("bp_result_held", result_o, vecs[0].res);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        wait fork;
        wait_drain();
        chk("bp_out_count", out_count - out0, 32'd4);

        // Mid-stream reset discards in-flight data.
        ready_i = 1'b0;
        send(vecs[2], 200);
        send(vecs[3], 201);
        rst_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("midreset_valid_o", {31'd0, valid_o}, 32'd0);
        sb.delete();
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("midreset_ready_o", {31'd0, ready_o}, 32'd1);

`ifdef FP_ROUND_ACCRUED_FLAGS_EN
        ready_i = 1'b1;
        send(vecs[0], 300);
        send(vecs[4], 301);
        wait_drain();
        chk("acc_nx_of", {27'd0, fflags_acc_o}, 32'h05);
        fflags_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        fflags_clr_i = 1'b0;
        chk("acc_clear", {27'd0, fflags_acc_o}, 32'h00);
        ready_i = 1'b0;
        send(vecs[8], 302);
        n = 0;
        while (!valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("acc_dz_valid", {31'd0, valid_o}, 32'd1);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        fflags_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        fflags_clr_i = 1'b0;
        chk("acc_clr_vs_dz", {27'd0, fflags_acc_o}, 32'h08);
`endif

        ready_i = 1'b1;
        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_round_unit.md
Name: fp_round_unit

Overview:
- Two-stage pipelined IEEE-754 single-precision rounding stage.
- Consumes the pre-rounded result and exception flags from the FP arithmetic units (divide, multiply, add), applies the RISC-V rounding mode and produces the final float and fflags for writeback.
- Valid/ready handshake on both sides. Stalls without losing data.

Parameters:
EXP_W, 8, exponent width
MANT_W, 23, stored mantissa width (hidden bit excluded)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous reset, active low
clk_en_i  in  1  global clock enable; low freezes all state
to_round_i  in  32  pre-rounded float (float_t): sign, exponent, mantissa
grs_i  in  3  guard, round, sticky bits below mantissa LSB
round_mode_i  in  3  instruction rm field
frm_i  in  3  fcsr dynamic rounding mode, used when round_mode_i=111
overflow_i  in  1  upstream overflow
underflow_i  in  1  upstream underflow (tiny result)
invalid_op_i  in  1  upstream invalid operation
zero_divide_i  in  1  upstream divide by zero
valid_i  in  1  input valid
ready_o  out  1  input accepted when valid_i & ready_o
result_o  out  32  rounded result
fflags_o  out  5  {NV,DZ,OF,UF,NX}
valid_o  out  1  output valid
ready_i  in  1  downstream ready

Behaviour:
- Reset (rst_n_i low at clock edge, independent of clk_en_i): both stage valids clear; result_o=0, fflags_o=0, valid_o=0. Any in-flight data is discarded.
- Handshake rules:
  - Stage-2 advances when ~s2_valid | ready_i. Stage-1 advances when ~s1_valid | s2 advances. ready_o equals the stage-1 advance condition.
  - Latency is 2 cycles from accept to valid_o with ready_i high.
  - Throughput is 1 result per cycle.
  - result_o, fflags_o and valid_o hold stable while valid_o & ~ready_i.
- Effective mode: rm = (round_mode_i==3'b111) ? frm_i : round_mode_i. The mode is latched at accept.
- Stage 1 (registered):
  - Decode special cases.
  - Compute increment inc, where L = mantissa LSB, G/R/S = grs_i, X = G|R|S:
    - RNE 000: G&(L|R|S)
    - RTZ 001: 0
    - RDN 010: sign&X
    - RUP 011: ~sign&X
    - RMM 100: G
  - NX = X for finite non-special inputs.
- Stage 2 (registered): {exp, mant} + inc as one 31-bit add, so a mantissa carry increments the exponent.
- Overflow occurs when the exponent sum reaches 8'hFF, or overflow_i=1. The result depends on mode:
  - RNE/RMM: ±inf (0x7F800000 | sign<<31).
  - RTZ: ±max finite (0x7F7FFFFF | sign<<31).
  - RDN: +max for positive, -inf for negative.
  - RUP: +inf for positive, -max for negative.
  - Flags: OF=1, NX=1.
- UF = underflow_i & NX. Subnormal results are passed through with the same increment logic (carry into exponent 1 allowed).
- Special inputs bypass rounding. Priority order, highest first:
  1. invalid_op_i, reserved rm (101/110), or NaN input (exp=FF, mant≠0): result 0x7FC00000; flags: NV=1 for invalid_op_i or reserved rm, 0 for NaN pass-through; OF/UF/NX=0.
  2. zero_divide_i: input passed unchanged (upstream supplies ±inf), DZ=1.
  3. ±inf input: passed unchanged, no flags.
  4. Zero input with grs=000: passed unchanged, no flags.
- Simultaneous overflow_i and underflow_i: overflow wins, UF=0.

Optional Feature:
- Macro: FP_ROUND_ACCRUED_FLAGS_EN.
- When defined:
  - Adds ports fflags_clr_i (in, 1) and fflags_acc_o (out, 5).
  - The register ORs in fflags_o on each output handshake (valid_o & ready_i).
  - fflags_clr_i clears it; a same-cycle handshake has priority over clear, so the new flags are kept.
  - The register resets to 0.
- Without the macro: no such ports and no accumulation logic.

Test Plan:
- RNE tie-to-even: 0x3F800001, grs=100 -> 0x3F800002, fflags 00001. 0x3F800000, grs=100 -> 0x3F800000, fflags 00001.
- Mantissa carry: 0x3FFFFFFF, grs=110, RUP -> 0x40000000, fflags 00001. Same input with RTZ -> 0x3FFFFFFF, fflags 00001.
- Overflow: 0x7F7FFFFF, grs=100, RNE -> 0x7F800000, fflags 00101. RTZ -> 0x7F7FFFFF. 0xFF7FFFFF with RUP -> 0xFF7FFFFF, fflags 00101.
- Specials: invalid_op_i=1 -> 0x7FC00000, fflags 10000. zero_divide_i=1 with 0xFF800000 -> 0xFF800000, fflags 01000. rm=101 -> 0x7FC00000, fflags 10000.
- Backpressure: 4 back-to-back inputs with ready_i low for 4 cycles -> ready_o drops after 2 accepts; all 4 outputs emerge in order, none lost or duplicated. Mid-stream reset -> valid_o=0 next cycle.
- FP_ROUND_ACCRUED_FLAGS_EN: NX result then OF result -> fflags_acc_o=00101. fflags_clr_i with no handshake -> 00000. Clear coincident with DZ handshake -> 01000.
